freq_counter_multi: RTL and testbench

Parametrised multi-channel gated frequency counter, successor to the single-channel frequency block. It synchronises CH asynchronous input signals and counts qualifying edges on each channel over a common gate window of GATE_CYCLES clocks. It latches per-channel results with saturation and overflow flags, and exposes one channel at a time through a read mux for the display path (bin_to_bcd / bcd_to_seg). Rising-only or both-edge counting is selectable at run time.

---
 rtl/freq_counter_multi.sv | 72 +++++++
 tb/tb_freq_counter_multi.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_counter_multi.sv
// freq_counter_multi: CH-channel gated edge counter with saturating latched results and a read mux
// Ports: clock, rst_n (async active-low); sig_in async inputs (bit i = channel i);
//   edge_mode 0 = rising only, 1 = both edges; hold freezes publishing at gate end;
//   rd_ch selects freq_out/ovf_out; ovf_all per-channel overflow flags;
//   meas_valid one-cycle pulse on publish; gate_busy high while windows run.
module freq_counter_multi #(
  parameter int CH = 4,
  parameter int CW = 32,
  parameter int GATE_CYCLES = 100000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                clock,
  input  logic                                rst_n,
  input  logic [CH-1:0]                       sig_in,
  input  logic                                edge_mode,
  input  logic                                hold,
  input  logic [$clog2(CH > 1 ? CH : 2)-1:0]  rd_ch,
  output logic [CW-1:0]                       freq_out,
  output logic                                ovf_out,
  output logic [CH-1:0]                       ovf_all,
  output logic                                meas_valid,
  output logic                                gate_busy
);
  localparam int GW = $clog2(GATE_CYCLES);
  logic [CH-1:0] sync_r [SYNC_STAGES];
  logic [CH-1:0] hist, last, edg, sat, ovf_w, ovf_nx, ovf_r;
  logic [CW-1:0] cnt [CH];
  logic [CW-1:0] cnt_nx [CH];
  logic [CW-1:0] res [CH];
  logic [GW-1:0] gt;
  logic term;
  assign last = sync_r[SYNC_STAGES-1];
  assign edg = edge_mode ? (last ^ hist) : (last & ~hist);
  assign term = gt == GW'(GATE_CYCLES - 1);
  // the terminal-cycle edge is folded into the published value via cnt_nx
  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign sat[i] = &cnt[i];
    assign cnt_nx[i] = sat[i] ? cnt[i] : cnt[i] + CW'(edg[i]);
  end
  assign ovf_nx = ovf_w | (edg & sat);
  assign freq_out = (32'(rd_ch) < CH) ? res[rd_ch] : '0;
  assign ovf_out = (32'(rd_ch) < CH) ? ovf_r[rd_ch] : 1'b0;
  assign ovf_all = ovf_r;
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt[i] <= '0;
        res[i] <= '0;
      end
      hist <= '0;
      ovf_w <= '0;
      ovf_r <= '0;
      gt <= '0;
      meas_valid <= 1'b0;
      gate_busy <= 1'b0;
    end else begin
      sync_r[0] <= sig_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
      hist <= last;
      gate_busy <= 1'b1;
      gt <= term ? '0 : gt + GW'(1);
      meas_valid <= term & ~hold;
      ovf_w <= term ? '0 : ovf_nx;
      for (int i = 0; i < CH; i++) cnt[i] <= term ? '0 : cnt_nx[i];
      if (term && !hold) begin
        for (int i = 0; i < CH; i++) res[i] <= cnt_nx[i];
        ovf_r <= ovf_nx;
      end
    end
  end
endmodule

// File: tb/tb_freq_counter_multi.sv
// tb_freq_counter_multi: checks two counter instances (CH=4/CW=16 and CH=3/CW=4) against an edge-list model
module tb_freq_counter_multi;
  localparam int G = 100;
  logic clock = 1'b0;
  always #10 clock = ~clock;
  logic rst_n, em, hold;
  logic [3:0] sig;
  logic [1:0] rd, rd_s;
  logic [15:0] freq_m;
  logic ovf_m, mv_m, busy_m;
  logic [3:0] ovfa_m;
  logic [3:0] freq_s;
  logic ovf_s, mv_s, busy_s;
  logic [2:0] ovfa_s;
  freq_counter_multi #(.CH(4), .CW(16), .GATE_CYCLES(G), .SYNC_STAGES(2)) u_main (
    .clock(clock), .rst_n(rst_n), .sig_in(sig), .edge_mode(em), .hold(hold), .rd_ch(rd),
    .freq_out(freq_m), .ovf_out(ovf_m), .ovf_all(ovfa_m), .meas_valid(mv_m), .gate_busy(busy_m));
  freq_counter_multi #(.CH(3), .CW(4), .GATE_CYCLES(G), .SYNC_STAGES(2)) u_small (
    .clock(clock), .rst_n(rst_n), .sig_in(sig[2:0]), .edge_mode(em), .hold(hold), .rd_ch(rd_s),
    .freq_out(freq_s), .ovf_out(ovf_s), .ovf_all(ovfa_s), .meas_valid(mv_s), .gate_busy(busy_s));
  typedef struct { int p0; int p1; logic em; int e0; int e1; } row_t;
  row_t rows [4];
  int n_chk, n_fail, e, tcount, p0, p1, n;
  int cnt [4];
  int pub [4];
  logic [3:0] prev;
  logic [3:0] q_nv [$];
  logic [3:0] q_chg [$];
  logic exp_mv, exp_busy;
  bit rnd_mode;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask
  function automatic int satv(int v, int mx);
    return v > mx ? mx : v;
  endfunction
  function automatic logic [3:0] omask(int mx);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = pub[i] > mx;
    return m;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      pub[i] = 0;
    end
    q_nv.delete();
    q_chg.delete();
    prev = '0;
    e = 0;
    exp_mv = 1'b0;
    exp_busy = 1'b0;
  endtask
  // a transition sampled at clock n is counted at clock n+2 under the edge_mode seen then
  task automatic model_edge();
    logic [3:0] nv, ch, q;
    if (q_nv.size() == 2) begin
      nv = q_nv.pop_front();
      ch = q_chg.pop_front();
      q = em ? ch : (ch & nv);
      for (int i = 0; i < 4; i++) if (q[i]) cnt[i]++;
    end
    q_nv.push_back(sig);
    q_chg.push_back(sig ^ prev);
    prev = sig;
    e++;
    exp_busy = 1'b1;
    exp_mv = 1'b0;
    if (e % G == 0) begin
      if (!hold) begin
        pub = cnt;
        exp_mv = 1'b1;
      end
      for (int i = 0; i < 4; i++) cnt[i] = 0;
    end
  endtask
  task automatic check_all();
    logic [3:0] ms;
    ms = omask(15);
    chk("mv", mv_m, exp_mv);
    chk("mv_s", mv_s, exp_mv);
    chk("busy", busy_m, exp_busy);
    chk("busy_s", busy_s, exp_busy);
    chk("freq", freq_m, satv(pub[rd], 65535));
    chk("ovf", ovf_m, pub[rd] > 65535);
    chk("ovf_all", ovfa_m, omask(65535));
    chk("freq_s", freq_s, rd_s < 3 ? satv(pub[rd_s], 15) : 0);
    chk("ovf_s", ovf_s, rd_s < 3 && pub[rd_s] > 15);
    chk("ovf_all_s", ovfa_s, ms[2:0]);
  endtask
  task automatic cyc();
    @(posedge clock);
    if (rst_n) model_edge();
    @(negedge clock);
    check_all();
    tcount++;
    if (rnd_mode) begin
      if (tcount % 2 == 0) sig = 4'($urandom);
      if ($urandom_range(0, 59) == 0) em = ~em;
      hold = ($urandom_range(0, 3) == 0);
      rd = 2'($urandom);
      rd_s = 2'($urandom);
    end else begin
      sig[0] = (tcount % p0) < (p0 / 2);
      sig[1] = (tcount % p1) < (p1 / 2);
    end
  endtask
  task automatic wait_mv(input int bound, output int k);
    k = 0;
    do begin
      cyc();
      k++;
    end while (mv_m !== 1'b1 && k < bound);
    if (mv_m !== 1'b1) chk("mv_wait", mv_m, 1'b1);
  endtask
  task automatic sweep_row(input row_t r);
    int ex [4];
    ex = '{r.e0, r.e1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      rd = 2'(i);
      rd_s = 2'(i);
      #1;
      chk("row_freq", freq_m, ex[i]);
      chk("row_freq_s", freq_s, i < 3 ? satv(ex[i], 15) : 0);
      chk("row_ovf_s", ovf_s, i < 3 && ex[i] > 15);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int mv_seen;
    rows[0] = '{10, 4, 1'b0, 10, 25};
    rows[1] = '{10, 4, 1'b1, 20, 50};
    rows[2] = '{4, 4, 1'b0, 25, 25};
    rows[3] = '{20, 10, 1'b0, 5, 10};
    n_chk = 0;
    n_fail = 0;
    tcount = 0;
    p0 = 10;
    p1 = 4;
    rnd_mode = 0;
    sig = 4'b1011;
    em = 0;
    hold = 0;
    rd = 0;
    rd_s = 0;
    rst_n = 0;
    model_reset();
    repeat (3) cyc();
    rst_n = 1;
    wait_mv(150, n);
    chk("first_mv_latency", n, 100);
    rd = 3;
    #1;
    chk("ch3_first_window", freq_m, 1);
    for (int r = 0; r < 4; r++) begin
      p0 = rows[r].p0;
      p1 = rows[r].p1;
      em = rows[r].em;
      wait_mv(150, n);
      wait_mv(150, n);
      chk("mv_period", n, 100);
      sweep_row(rows[r]);
    end
    rd = 0;
    hold = 1;
    mv_seen = 0;
    for (int i = 0; i < 205; i++) begin
      if (i == 180) p0 = 4;
      cyc();
      if (mv_m) mv_seen++;
    end
    chk("hold_no_mv", mv_seen, 0);
    chk("hold_freeze", freq_m, 5);
    hold = 0;
    wait_mv(150, n);
    chk("hold_release_latency", n, 95);
    chk("hold_release_rate", freq_m, 25);
    em = 1;
    repeat (97) cyc();
    sig[2] = 1'b1;
    cyc();
    sig[2] = 1'b0;
    repeat (2) cyc();
    chk("edge_term_mv", mv_m, 1'b1);
    rd = 2;
    rd_s = 2;
    #1;
    chk("edge_term_ch2", freq_m, 1);
    chk("edge_term_ch2_s", freq_s, 1);
    wait_mv(150, n);
    rd = 2;
    rd_s = 2;
    #1;
    chk("edge_next_ch2", freq_m, 1);
    chk("edge_next_ch2_s", freq_s, 1);
    repeat (50) cyc();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_freq", freq_m, 0);
    chk("rst_ovf_all", ovfa_m, 0);
    chk("rst_mv", mv_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_freq_s", freq_s, 0);
    repeat (2) cyc();
    rst_n = 1;
    wait_mv(150, n);
    chk("rst_mv_latency", n, 100);
    for (int i = 0; i < 4; i++) begin
      rd = 2'(i);
      #1;
      chk("rst_sweep", freq_m, pub[i]);
    end
    chk("rst_ch3", freq_m, 1);
    rd_s = 3;
    #1;
    chk("rd_beyond_ch", freq_s, 0);
    chk("rd_beyond_ovf", ovf_s, 0);
    rnd_mode = 1;
    repeat (800) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
